// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: bus word, RAM status and the RAM arbiter state.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DGRANT = 2'd2
   } arbstate_t;

   localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_streak_counter #(
   parameter int unsigned Width  = 4,
   parameter int unsigned MaxVal = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [Width-1:0] count_o
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != Width'(MaxVal))) begin
         count_d = count_q + Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single RAM port between icache and dcache, dcache first with bounded icache starvation.
// Define ARB_STATS_EN to add the igrant_cnt/dgrant_cnt completed-transaction counters.
module cache_mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned MAX_DSTREAK = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        arb_err
`ifdef ARB_STATS_EN
   ,
   output logic [31:0] igrant_cnt,
   output logic [31:0] dgrant_cnt
`endif
);

   arbstate_t           state_q, state_d;
   ramstate_t           rs;
   logic [STREAK_W-1:0] streak;
   logic                i_done, d_done;

   assign rs    = ramstate_t'(ramstate);
   assign iload = ramload;
   assign dload = ramload;

   always_comb begin
      state_d  = state_q;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      arb_err  = 1'b0;
      i_done   = 1'b0;
      d_done   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (iREN && (streak == STREAK_W'(MAX_DSTREAK))) begin
               state_d = IGRANT;
            end else if (dREN || dWEN) begin
               state_d = DGRANT;
            end else if (iREN) begin
               state_d = IGRANT;
            end
         end
         DGRANT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            if (!(dREN || dWEN)) begin
               state_d = IDLE;
            end else begin
               // A write wins when both enables are raised.
               ramWEN  = dWEN;
               ramREN  = dREN & ~dWEN;
               arb_err = (rs == ERROR);
               if (rs == ACCESS) begin
                  dwait   = 1'b0;
                  d_done  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         IGRANT: begin
            ramaddr = iaddr;
            if (!iREN) begin
               state_d = IDLE;
            end else begin
               ramREN  = 1'b1;
               arb_err = (rs == ERROR);
               if (rs == ACCESS) begin
                  iwait   = 1'b0;
                  i_done  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Counts dcache completions that overtook a waiting icache fetch.
   arb_streak_counter #(
      .Width  (STREAK_W),
      .MaxVal (MAX_DSTREAK)
   ) u_streak (
      .clk_i   (CLK),
      .rst_ni  (nRST),
      .clr_i   (~iREN | i_done),
      .inc_i   (d_done & iREN),
      .count_o (streak)
   );

`ifdef ARB_STATS_EN
   logic [31:0] igrant_q, dgrant_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         igrant_q <= '0;
         dgrant_q <= '0;
      end else begin
         if (i_done) igrant_q <= igrant_q + 32'd1;
         if (d_done) dgrant_q <= dgrant_q + 32'd1;
      end
   end

   assign igrant_cnt = igrant_q;
   assign dgrant_cnt = dgrant_q;
`endif

endmodule
